// File: rtl/alu_mul_seq.sv
// 16x16 unsigned shift-add multiplier that uses an external ALU as its adder; start to done pulse is 17 cycles.
// No backpressure: start is taken only in IDLE or DONE, is ignored during RUN, and the product holds until the next accepted start.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [3:0]  alu_op,
    output logic        alu_mode,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_cin,
    input  logic [15:0] alu_z,
    input  logic        alu_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] acc;
    logic [15:0] mq;
    logic [15:0] mcand;
    logic [3:0]  cnt;

    // ALU is strapped to "A plus B" with its active-low carry-in inactive.
    assign alu_op   = 4'b1001;
    assign alu_mode = 1'b0;
    assign alu_cin  = 1'b1;
    assign alu_x    = acc;
    assign alu_y    = mq[0] ? mcand : 16'h0000;
    assign product  = {acc, mq};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= 16'h0000;
            mq    <= 16'h0000;
            mcand <= 16'h0000;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= 16'h0000;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out is active-low; it becomes the new top bit of the shifted pair.
                    {acc, mq} <= {~alu_cout, alu_z, mq[15:1]};
                    cnt       <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= 16'h0000;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural "A plus B" ALU attached to its ALU port.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [3:0]  alu_op;
    logic        alu_mode;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_cin;
    logic [15:0] alu_z;
    logic        alu_cout;
    logic        alu_c;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_seen = 0;
    bit          saw_cout = 1'b0;
    logic [15:0] exp_mcand = 16'h0000;

    always #5 clk = ~clk;

    // External ALU: plain 16-bit add, active-low carry-out.
    assign {alu_c, alu_z} = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_cout = ~alu_c;

    alu_mul_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .alu_op   (alu_op),
        .alu_mode (alu_mode),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_cin  (alu_cin),
        .alu_z    (alu_z),
        .alu_cout (alu_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ALU contract and done/carry bookkeeping on every cycle.
    always @(negedge clk) begin
        check("alu_op", {28'd0, alu_op}, 32'h9);
        check("alu_mode", {31'd0, alu_mode}, 32'h0);
        check("alu_cin", {31'd0, alu_cin}, 32'h1);
        check("alu_y_sel", {31'd0, (alu_y === 16'h0000) || (alu_y === exp_mcand)}, 32'h1);
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1 && alu_cout === 1'b0) saw_cout = 1'b1;
    end

    task automatic mul(input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] exp, input string tag);
        int  k;
        int  bcnt;
        bit  got;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        exp_mcand = ta;
        k = 0; bcnt = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (k == 1) begin
                a = 16'hA5A5; b = 16'h5A5A;
            end
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'h1);
        check({tag, "_done_cycle"}, 32'(k), 32'd17);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, "_product"}, product, exp);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'h0);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        int          d0;
        int          k1;
        int          k2;
        logic [31:0] p2;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_product", product, 32'h0);
        check("rst_alu_x", {16'd0, alu_x}, 32'h0);
        check("rst_alu_y", {16'd0, alu_y}, 32'h0);
        reset = 1'b0;

        // Basic and extra patterns
        mul(16'h0003, 16'h0005, 32'h0000000F, "basic");
        mul(16'h8001, 16'h0003, 32'h00018003, "msb");
        saw_cout = 1'b0;
        mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "carry");
        check("carry_cout_seen", {31'd0, saw_cout}, 32'h1);

        // Zero product with an ignored start during RUN
        @(negedge clk);
        a = 16'h1234; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        exp_mcand = 16'h1234;
        d0 = done_seen; k1 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 4);
            if (k == 4) begin
                a = 16'h0002; b = 16'h0002;
            end
            if (done === 1'b1 && k1 == 0) k1 = k;
        end
        check("ign_done_count", 32'(done_seen - d0), 32'd1);
        check("ign_done_cycle", 32'(k1), 32'd17);
        check("ign_product", product, 32'h0);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        a = 16'h0007; b = 16'h0009; start = 1'b1;
        @(posedge clk);
        exp_mcand = 16'h0007;
        k2 = 0; p2 = 32'hDEADBEEF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 16 || k == 17);
            if (k == 16) begin
                a = 16'h00FF; b = 16'h0101;
            end
            if (k == 17) begin
                check("b2b_first_done", {31'd0, done}, 32'h1);
                check("b2b_first_product", product, 32'h0000003F);
                @(posedge clk);
                exp_mcand = 16'h00FF;
            end
            if (k == 18) begin
                check("b2b_run_resumes", {31'd0, busy}, 32'h1);
                check("b2b_no_done", {31'd0, done}, 32'h0);
            end
            if (k > 17 && done === 1'b1 && k2 == 0) begin
                k2 = k;
                p2 = product;
            end
        end
        check("b2b_second_cycle", 32'(k2), 32'd34);
        check("b2b_second_product", p2, 32'h0000FFFF);

        // Reset asserted mid-RUN, between clock edges
        @(negedge clk);
        a = 16'h1234; b = 16'h0013; start = 1'b1;
        @(posedge clk);
        exp_mcand = 16'h1234;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy_before", {31'd0, busy}, 32'h1);
        d0 = done_seen;
        #2 reset = 1'b1;
        #1;
        check("mid_busy", {31'd0, busy}, 32'h0);
        check("mid_product", product, 32'h0);
        check("mid_done", {31'd0, done}, 32'h0);
        check("mid_alu_x", {16'd0, alu_x}, 32'h0);
        check("mid_alu_y", {16'd0, alu_y}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_no_done", 32'(done_seen - d0), 32'd0);
        check("mid_idle", {31'd0, busy}, 32'h0);
        mul(16'h1234, 16'h0013, 32'h000159DC, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16-bit operands and a 32-bit product.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-003 The ports SHALL be, in order:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request a multiply; sampled at rising clk
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse; product valid
- product  output  32  result; held until the next accepted start
- alu_op  output  4  to the 16-bit ALU s-select
- alu_mode  output  1  to the ALU m input
- alu_x  output  16  to the ALU x operand
- alu_y  output  16  to the ALU y operand
- alu_cin  output  1  to the ALU carry-in, active-low (1 = no carry)
- alu_z  input  16  ALU result
- alu_cout  input  1  ALU carry-out, active-low (0 = carry)

Function
REQ-004 The block SHALL compute unsigned a*b by shift-add over 16 iterations, using the external ALU as its only adder.
REQ-005 The block SHALL drive the ALU outputs as constants: alu_op = 4'b1001, alu_mode = 0, alu_cin = 1 (A plus B, no carry-in).
REQ-006 The block SHALL hold these registers: acc[15:0], mq[15:0], mcand[15:0] and cnt[3:0].
REQ-007 The block SHALL drive alu_x = acc.
REQ-008 The block SHALL drive alu_y = mcand when mq[0] = 1, and alu_y = 16'h0000 otherwise.
REQ-009 The ALU SHALL be treated as combinational, with alu_z and alu_cout settling within one clk period.
REQ-010 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-011 In IDLE, start = 1 SHALL load mcand <= a, mq <= b, acc <= 0 and cnt <= 0, and move the state to RUN.
REQ-012 In IDLE with start = 0, the state SHALL remain IDLE.
REQ-013 Each RUN cycle SHALL update {acc, mq} <= {~alu_cout, alu_z, mq[15:1]} and increment cnt.
REQ-014 In RUN, the state SHALL move to DONE on the edge where cnt = 15 (the 16th iteration), with cnt wrapping to 0.
REQ-015 In RUN, start SHALL be ignored, with operands and iteration unaffected.
REQ-016 In DONE, the block SHALL assert done = 1 for exactly one cycle.
REQ-017 From DONE, the state SHALL move to IDLE, unless start = 1, in which case it SHALL reload per REQ-011 and move directly to RUN (back-to-back operation).
REQ-018 The outputs SHALL be product = {acc, mq} at all times, busy = 1 only in RUN, and done = 1 only in DONE.
REQ-019 Latency SHALL be: start accepted at edge E0; RUN occupies the cycles after edges E0..E15; done = 1 in the cycle after E16.
REQ-020 A product result SHALL remain stable from DONE until the edge that accepts the next start.
REQ-021 The a and b inputs SHALL be sampled only at start acceptance; changes to them during RUN SHALL have no effect.

Reset
REQ-022 Asserting reset SHALL force, without waiting for clk: state = IDLE, acc = mq = mcand = 0, cnt = 0, busy = 0, done = 0, product = 32'h0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-024 On reset release, the first start SHALL be accepted normally.
REQ-025 The ALU-side outputs SHALL remain at their REQ-005 constants during and after reset; alu_x = 0 and alu_y = 0 while in reset.

Verification
REQ-026 Basic multiply: a = 16'h0003, b = 16'h0005, start pulsed one cycle -> busy high 16 cycles, done pulse in the 17th cycle after the start edge, product = 32'h0000000F.
REQ-027 Carry path: a = 16'hFFFF, b = 16'hFFFF -> product = 32'hFFFE0001, and alu_cout = 0 observed on at least one iteration.
REQ-028 Zero and ignored start: a = 16'h1234, b = 16'h0000 -> product = 0; a second start pulse with a = 16'h0002, b = 16'h0002 issued during RUN is ignored, with exactly one done and product = 0.
REQ-029 Back-to-back: start held high through the DONE cycle with the new operands a = 16'h00FF, b = 16'h0101 -> the first done pulses, RUN resumes the next cycle, and the second product = 32'h0000FFFF.
REQ-030 Reset mid-RUN: reset asserted asynchronously at iteration 8 -> immediately busy = 0 and product = 0; no done pulse; the next start computes correctly.
REQ-031 ALU contract: throughout all scenarios, alu_op = 4'b1001, alu_mode = 0, alu_cin = 1, and alu_y is either mcand or 16'h0000 on every cycle.
